// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the hold-FSM state type used by the manager-side hold stage.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_WAIT = 2'd1,
        DATA      = 2'd2
    } hold_state_t;

    // BUSY and IDLE carry no transfer, so only NONSEQ/SEQ start one.
    function automatic logic is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_addr_reg.sv
// Load-enable hold register for one captured AHB address phase.
module ahb_addr_reg #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] d_haddr,
    input  logic                  d_hwrite,
    input  logic [2:0]            d_hsize,
    input  logic [3:0]            d_hprot,
    output logic [ADDR_WIDTH-1:0] q_haddr,
    output logic                  q_hwrite,
    output logic [2:0]            q_hsize,
    output logic [3:0]            q_hprot
);

    logic [ADDR_WIDTH-1:0] haddr_r;
    logic                  hwrite_r;
    logic [2:0]            hsize_r;
    logic [3:0]            hprot_r;

    // capture the address phase when load is asserted, otherwise hold
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_r  <= {ADDR_WIDTH{1'b0}};
            hwrite_r <= 1'b0;
            hsize_r  <= 3'd0;
            hprot_r  <= 4'd0;
        end else if (load) begin
            haddr_r  <= d_haddr;
            hwrite_r <= d_hwrite;
            hsize_r  <= d_hsize;
            hprot_r  <= d_hprot;
        end else begin
            haddr_r  <= haddr_r;
            hwrite_r <= hwrite_r;
            hsize_r  <= hsize_r;
            hprot_r  <= hprot_r;
        end
    end

    assign q_haddr  = haddr_r;
    assign q_hwrite = hwrite_r;
    assign q_hsize  = hsize_r;
    assign q_hprot  = hprot_r;

endmodule

// File: rtl/ahb_mgr_hold.sv
// Holds one manager address phase until the bus arbiter grants the mux, then
// replays it as a NONSEQ/SINGLE transfer and passes the data phase back.
module ahb_mgr_hold
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] s_haddr,
    input  logic [1:0]            s_htrans,
    input  logic                  s_hwrite,
    input  logic [2:0]            s_hsize,
    input  logic [2:0]            s_hburst,
    input  logic [3:0]            s_hprot,
    input  logic [DATA_WIDTH-1:0] s_hwdata,
    output logic                  s_hreadyout,
    output logic [DATA_WIDTH-1:0] s_hrdata,
    output logic                  s_hresp,
    output logic                  mgr_req,
    input  logic                  mgr_grant,
    output logic [ADDR_WIDTH-1:0] m_haddr,
    output logic [1:0]            m_htrans,
    output logic                  m_hwrite,
    output logic [2:0]            m_hsize,
    output logic [2:0]            m_hburst,
    output logic [3:0]            m_hprot,
    output logic [DATA_WIDTH-1:0] m_hwdata,
    input  logic                  m_hready,
    input  logic [DATA_WIDTH-1:0] m_hrdata,
    input  logic                  m_hresp,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    hold_state_t          state_r;
    hold_state_t          state_nxt_s;
    logic                 capture_s;
    logic [CNT_WIDTH-1:0] stall_cnt_r;
    logic                 unused_hburst_s;

    // Bursts are split into singles, so the manager's burst type is not needed.
    assign unused_hburst_s = ^s_hburst;

    // A new phase is accepted whenever the manager sees HREADYOUT high.
    assign capture_s = is_active(s_htrans) &&
                       ((state_r == IDLE) || ((state_r == DATA) && m_hready));

    ahb_addr_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_reg (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .load     (capture_s),
        .d_haddr  (s_haddr),
        .d_hwrite (s_hwrite),
        .d_hsize  (s_hsize),
        .d_hprot  (s_hprot),
        .q_haddr  (m_haddr),
        .q_hwrite (m_hwrite),
        .q_hsize  (m_hsize),
        .q_hprot  (m_hprot)
    );

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // grant-wait counter: cleared on entry to ADDR_WAIT, saturating while there
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (capture_s) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if ((state_r == ADDR_WAIT) && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // next-state and per-state bus outputs
    always_comb begin
        state_nxt_s = state_r;
        s_hreadyout = 1'b1;
        s_hresp     = HRESP_OKAY;
        s_hrdata    = {DATA_WIDTH{1'b0}};
        mgr_req     = 1'b0;
        m_htrans    = HTRANS_IDLE;
        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    state_nxt_s = ADDR_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR_WAIT: begin
                s_hreadyout = 1'b0;
                mgr_req     = 1'b1;
                if (mgr_grant) begin
                    m_htrans = HTRANS_NONSEQ;
                    if (m_hready) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = ADDR_WAIT;
                    end
                end else begin
                    state_nxt_s = ADDR_WAIT;
                end
            end
            DATA: begin
                mgr_req     = 1'b1;
                s_hreadyout = m_hready;
                s_hrdata    = m_hrdata;
                s_hresp     = m_hresp;
                if (m_hready) begin
                    if (capture_s) begin
                        state_nxt_s = ADDR_WAIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign m_hburst  = HBURST_SINGLE;
    assign m_hwdata  = s_hwdata;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_ahb_mgr_hold.sv
// Directed bench for ahb_mgr_hold: stimulus pushes expected mux-side address
// phases and manager-side responses; a monitor pops and compares them.
module tb_ahb_mgr_hold;

    logic        HCLK, HRESETn;
    logic [31:0] s_haddr, s_hwdata, s_hrdata, m_haddr, m_hwdata, m_hrdata;
    logic [1:0]  s_htrans, m_htrans;
    logic [2:0]  s_hsize, s_hburst, m_hsize, m_hburst;
    logic [3:0]  s_hprot, m_hprot;
    logic        s_hwrite, s_hreadyout, s_hresp, mgr_req, mgr_grant;
    logic        m_hwrite, m_hready, m_hresp;
    logic [7:0]  stall_cnt;

    typedef struct { logic [31:0] addr; logic wr; logic [2:0] size; logic [3:0] prot; } addr_exp_t;
    typedef struct { logic [31:0] rdata; logic [31:0] wdata; logic resp; logic rd; } resp_exp_t;

    addr_exp_t   exp_addr_q[$];
    resp_exp_t   exp_resp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        data_pend = 1'b0;
    logic        gnt_v[0:319];
    logic        rdy_v[0:319];
    logic        rsp_v[0:319];
    logic [31:0] seq_addr[0:3];
    logic [31:0] rd_word;
    logic        exp_err;
    logic [2:0]  cur_burst;
    int          lows, ev;

    ahb_mgr_hold #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hwdata(s_hwdata),
        .s_hreadyout(s_hreadyout), .s_hrdata(s_hrdata), .s_hresp(s_hresp),
        .mgr_req(mgr_req), .mgr_grant(mgr_grant),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwdata(m_hwdata),
        .m_hready(m_hready), .m_hrdata(m_hrdata), .m_hresp(m_hresp),
        .stall_cnt(stall_cnt)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic set_sched(input logic g, input logic r);
        for (int c = 0; c < 320; c++) begin
            gnt_v[c] = g;
            rdy_v[c] = r;
            rsp_v[c] = 1'b0;
        end
    endtask

    // arbiter/subordinate side: one table entry per cycle
    task automatic run_sched(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge HCLK); #1;
            mgr_grant = gnt_v[c];
            m_hready  = rdy_v[c];
            m_hresp   = rsp_v[c];
        end
    endtask

    task automatic issue(input int i, input logic [1:0] tr, input logic wr);
        s_htrans = tr;
        s_haddr  = seq_addr[i];
        s_hwrite = wr;
        s_hsize  = 3'd2;
        s_hburst = cur_burst;
        s_hprot  = 4'h3;
        exp_addr_q.push_back('{addr: seq_addr[i], wr: wr, size: 3'd2, prot: 4'h3});
        exp_resp_q.push_back('{rdata: rd_word, wdata: 32'hA500_0000 ^ seq_addr[i],
                               resp: exp_err, rd: ~wr});
    endtask

    // manager model: holds each address phase until it sees s_hreadyout high
    task automatic run_xfers(input int n, input logic wr, output int n_low, output int n_ev);
        int   i;
        logic rdy;
        i = 0;
        n_low = 0;
        n_ev = 0;
        @(posedge HCLK); #1;
        issue(0, 2'b10, wr);
        for (int k = 0; k < 400; k++) begin
            @(negedge HCLK);
            rdy = s_hreadyout;
            if (rdy) begin
                n_ev++;
                if (n_ev == n + 1) break;
            end else begin
                n_low++;
            end
            @(posedge HCLK); #1;
            if (rdy) begin
                s_hwdata = 32'hA500_0000 ^ seq_addr[i];
                i++;
                if (i < n) issue(i, 2'b11, wr);
                else s_htrans = 2'b00;
            end
        end
    endtask

    // monitor: mux-side address acceptance and manager-side data completion
    initial begin
        addr_exp_t ea;
        resp_exp_t er;
        logic      pend_before;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                data_pend = 1'b0;
            end else begin
                pend_before = data_pend;
                if (data_pend) begin
                    if (m_hready) begin
                        if (exp_resp_q.size() == 0) begin
                            chk("resp_queue_nonempty", 32'd0, 32'd1);
                        end else begin
                            er = exp_resp_q.pop_front();
                            chk("done_hreadyout", s_hreadyout, 1'b1);
                            chk("done_hresp", s_hresp, er.resp);
                            chk("done_hwdata", m_hwdata, er.wdata);
                            if (er.rd) chk("done_hrdata", s_hrdata, er.rdata);
                        end
                        data_pend = 1'b0;
                    end else begin
                        chk("wait_hreadyout", s_hreadyout, 1'b0);
                        if (exp_resp_q.size() > 0) chk("wait_hresp", s_hresp, exp_resp_q[0].resp);
                    end
                end
                if (m_htrans == 2'b10 && m_hready) begin
                    chk("no_overlap", pend_before, 1'b0);
                    if (exp_addr_q.size() == 0) begin
                        chk("addr_queue_nonempty", 32'd0, 32'd1);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        chk("m_haddr", m_haddr, ea.addr);
                        chk("m_hwrite", m_hwrite, ea.wr);
                        chk("m_hsize", m_hsize, ea.size);
                        chk("m_hprot", m_hprot, ea.prot);
                        chk("m_hburst", m_hburst, 3'd0);
                    end
                    data_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETn = 1'b0; mgr_grant = 1'b0; m_hready = 1'b1; m_hresp = 1'b0;
        m_hrdata = 32'd0; s_haddr = 32'd0; s_htrans = 2'b00; s_hwrite = 1'b0;
        s_hsize = 3'd0; s_hburst = 3'd0; s_hprot = 4'd0; s_hwdata = 32'd0;
        rd_word = 32'd0; exp_err = 1'b0; cur_burst = 3'd0;
        #3;
        chk("rst_hreadyout", s_hreadyout, 1'b1);
        chk("rst_mgr_req", mgr_req, 1'b0);
        chk("rst_m_htrans", m_htrans, 2'b00);
        chk("rst_hresp", s_hresp, 1'b0);
        chk("rst_stall", stall_cnt, 8'd0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // BUSY in IDLE must not start a transfer
        s_htrans = 2'b01; s_haddr = 32'h9000;
        @(posedge HCLK); #1 s_htrans = 2'b00;
        @(negedge HCLK);
        chk("busy_mgr_req", mgr_req, 1'b0);
        chk("busy_hreadyout", s_hreadyout, 1'b1);

        // zero-wait write with grant already present
        seq_addr[0] = 32'h1000; set_sched(1'b1, 1'b1);
        fork
            run_xfers(1, 1'b1, lows, ev);
            run_sched(4);
        join
        chk("w1000_events", ev, 2); chk("w1000_lows", lows, 1); chk("w1000_stall", stall_cnt, 8'd1);

        // read with grant delayed five cycles
        seq_addr[0] = 32'h2000; m_hrdata = 32'hDEADBEEF; rd_word = 32'hDEADBEEF;
        set_sched(1'b1, 1'b1);
        for (int c = 0; c < 6; c++) gnt_v[c] = 1'b0;
        fork
            run_xfers(1, 1'b0, lows, ev);
            run_sched(9);
            begin
                repeat (7) @(posedge HCLK);
                @(negedge HCLK);
                chk("r2000_stall_at_grant", stall_cnt, 8'd5);
                chk("r2000_nonseq", m_htrans, 2'b10);
            end
        join
        chk("r2000_events", ev, 2); chk("r2000_lows", lows, 6);

        // INCR4 burst split into four singles
        cur_burst = 3'd3; rd_word = 32'd0;
        seq_addr[0] = 32'h3000; seq_addr[1] = 32'h3004; seq_addr[2] = 32'h3008; seq_addr[3] = 32'h300C;
        set_sched(1'b1, 1'b1);
        fork
            run_xfers(4, 1'b1, lows, ev);
            run_sched(10);
        join
        chk("incr4_events", ev, 5); chk("incr4_lows", lows, 4);
        cur_burst = 3'd0;

        // two-cycle ERROR response passes through
        seq_addr[0] = 32'h4000; exp_err = 1'b1; rd_word = 32'hDEADBEEF;
        set_sched(1'b1, 1'b1);
        rdy_v[2] = 1'b0; rsp_v[2] = 1'b1; rsp_v[3] = 1'b1;
        fork
            run_xfers(1, 1'b0, lows, ev);
            run_sched(5);
        join
        chk("err_events", ev, 2); chk("err_lows", lows, 2);
        @(negedge HCLK);
        chk("err_idle_req", mgr_req, 1'b0); chk("err_idle_ready", s_hreadyout, 1'b1);
        chk("err_idle_resp", s_hresp, 1'b0);
        exp_err = 1'b0;

        // grant withdrawn for two cycles while the mux is stalled
        seq_addr[0] = 32'h5000; set_sched(1'b1, 1'b1);
        rdy_v[1] = 1'b0; gnt_v[2] = 1'b0; rdy_v[2] = 1'b0; gnt_v[3] = 1'b0; rdy_v[3] = 1'b0;
        fork
            run_xfers(1, 1'b1, lows, ev);
            run_sched(7);
            begin
                repeat (2) @(posedge HCLK);
                @(negedge HCLK);
                chk("gtog_c1_nonseq", m_htrans, 2'b10);
                repeat (2) begin
                    @(negedge HCLK);
                    chk("gtog_idle", m_htrans, 2'b00);
                    chk("gtog_addr", m_haddr, 32'h5000);
                    chk("gtog_req", mgr_req, 1'b1);
                end
            end
        join
        chk("gtog_events", ev, 2); chk("gtog_lows", lows, 4); chk("gtog_stall", stall_cnt, 8'd4);

        // 300+ cycles without grant: counter saturates
        seq_addr[0] = 32'h7000; set_sched(1'b1, 1'b1);
        for (int c = 0; c <= 300; c++) gnt_v[c] = 1'b0;
        fork
            run_xfers(1, 1'b0, lows, ev);
            run_sched(304);
        join
        chk("sat_events", ev, 2); chk("sat_lows", lows, 301); chk("sat_stall", stall_cnt, 8'd255);

        // counter clears on the next transfer
        seq_addr[0] = 32'h7100; set_sched(1'b1, 1'b1);
        fork
            run_xfers(1, 1'b1, lows, ev);
            run_sched(4);
        join
        chk("clr_events", ev, 2); chk("clr_stall", stall_cnt, 8'd1);

        // asynchronous reset during a stalled data phase
        mgr_grant = 1'b1; m_hready = 1'b1;
        @(posedge HCLK); #1;
        s_htrans = 2'b10; s_haddr = 32'h6000; s_hwrite = 1'b1; s_hsize = 3'd2; s_hprot = 4'h3;
        exp_addr_q.push_back('{addr: 32'h6000, wr: 1'b1, size: 3'd2, prot: 4'h3});
        @(posedge HCLK); #1 s_htrans = 2'b00;
        @(posedge HCLK); #1 m_hready = 1'b0;
        #1;
        chk("pre_rst_data_ready", s_hreadyout, 1'b0); chk("pre_rst_data_req", mgr_req, 1'b1);
        #1 HRESETn = 1'b0;
        #1;
        chk("arst_mgr_req", mgr_req, 1'b0); chk("arst_m_htrans", m_htrans, 2'b00);
        chk("arst_hreadyout", s_hreadyout, 1'b1); chk("arst_hresp", s_hresp, 1'b0);
        chk("arst_stall", stall_cnt, 8'd0); chk("arst_haddr", m_haddr, 32'd0);
        @(posedge HCLK); @(posedge HCLK); #1;
        HRESETn = 1'b1; m_hready = 1'b1;
        @(negedge HCLK);
        chk("post_rst_ready", s_hreadyout, 1'b1); chk("post_rst_req", mgr_req, 1'b0);
        chk("post_rst_htrans", m_htrans, 2'b00);

        @(negedge HCLK);
        chk("addr_queue_empty", exp_addr_q.size(), 32'd0);
        chk("resp_queue_empty", exp_resp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_mgr_hold.md
AHB_MGR_HOLD -- requirements
Module: ahb_mgr_hold

Interface
REQ-001 Parameter ADDR_WIDTH, 32, HADDR width.
REQ-002 Parameter DATA_WIDTH, 32, HWDATA/HRDATA width.
REQ-003 Parameter CNT_WIDTH, 8, stall counter width.
REQ-004 The block SHALL use one clock, HCLK; reset is HRESETn, asynchronous, active-low.
REQ-005 HCLK  in  1  clock.
REQ-006 HRESETn  in  1  async active-low reset.
REQ-007 s_haddr/s_htrans/s_hwrite/s_hsize/s_hburst/s_hprot  in  ADDR_WIDTH/2/1/3/3/4  manager address phase.
REQ-008 s_hwdata  in  DATA_WIDTH  manager write data.
REQ-009 s_hreadyout  out  1  ready to manager; s_hrdata  out  DATA_WIDTH; s_hresp  out  1.
REQ-010 mgr_req  out  1  bus request to mux arbiter; mgr_grant  in  1  grant from arbiter.
REQ-011 m_haddr/m_htrans/m_hwrite/m_hsize/m_hburst/m_hprot  out  same widths  address phase to mux.
REQ-012 m_hwdata  out  DATA_WIDTH; m_hready  in  1; m_hrdata  in  DATA_WIDTH; m_hresp  in  1  mux side.
REQ-013 stall_cnt  out  CNT_WIDTH  cycles spent waiting for grant on current transfer.

Function
REQ-014 FSM states IDLE, ADDR_WAIT, DATA; one transfer in flight maximum.
REQ-015 IDLE: s_hreadyout=1, s_hresp=OKAY, mgr_req=0, m_htrans=IDLE.
REQ-016 IDLE with s_htrans in {NONSEQ,SEQ}: capture address phase into hold register, go ADDR_WAIT; BUSY/IDLE ignored.
REQ-017 ADDR_WAIT: s_hreadyout=0, s_hresp=OKAY, mgr_req=1, stall_cnt increments each cycle, saturating at all-ones.
REQ-018 ADDR_WAIT with mgr_grant=1: drive held phase on m_*, m_htrans forced NONSEQ, m_hburst forced SINGLE; otherwise m_htrans=IDLE.
REQ-019 ADDR_WAIT with mgr_grant=1 and m_hready=1: go DATA; with m_hready=0, hold m_* stable and remain.
REQ-020 Grant withdrawn in ADDR_WAIT: remain in ADDR_WAIT, held phase retained, no transfer lost.
REQ-021 DATA: mgr_req=1, m_htrans=IDLE, s_hreadyout=m_hready, s_hrdata=m_hrdata, s_hresp=m_hresp; mgr_grant ignored.
REQ-022 m_hwdata=s_hwdata combinationally in all states.
REQ-023 DATA with m_hready=1: if s_htrans in {NONSEQ,SEQ}, capture and go ADDR_WAIT (mgr_req stays 1); else go IDLE.
REQ-024 Two-cycle ERROR (m_hresp=1 with m_hready 0 then 1) SHALL pass through unmodified; no retry.
REQ-025 stall_cnt clears to 0 on every entry to ADDR_WAIT and holds its value in DATA and IDLE.
REQ-026 Added latency: minimum 1 wait state per transfer (grant present on first ADDR_WAIT cycle, zero-wait subordinate).

Reset
REQ-027 HRESETn low: state=IDLE, mgr_req=0, s_hreadyout=1, s_hresp=0, m_htrans=IDLE, stall_cnt=0, hold register=0, immediately (asynchronously).
REQ-028 Reset asserted mid-transfer SHALL discard the held phase; first post-reset cycle is IDLE.

Structure
REQ-029 Shared package ahb_pkg SHALL hold htrans_t (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), hburst SINGLE=0, HRESP OKAY=0/ERROR=1, hold_state_t.
REQ-030 Address-phase capture SHALL be sub-module ahb_addr_reg (load-enable register of haddr/hwrite/hsize/hprot).

Verification
REQ-031 NONSEQ write 0x1000, grant held, zero-wait -> m_htrans=NONSEQ one cycle after capture, s_hreadyout low 1 cycle, stall_cnt=1.
REQ-032 NONSEQ read 0x2000, grant delayed 5 cycles, m_hrdata=0xDEADBEEF -> s_hreadyout low 6 cycles, s_hrdata=0xDEADBEEF, stall_cnt=5.
REQ-033 INCR4 burst from 0x3000 -> four m_* NONSEQ/SINGLE transfers at 0x3000/4/8/C, IDLE between each.
REQ-034 Subordinate ERROR on 0x4000 -> s_hresp=1 with s_hreadyout 0 then 1, FSM returns to IDLE.
REQ-035 Grant toggled off for 2 cycles in ADDR_WAIT with m_hready=0 -> held address unchanged, single transfer completes.
REQ-036 HRESETn asserted in DATA -> same cycle mgr_req=0, m_htrans=IDLE, s_hreadyout=1; stall_cnt saturates at 255 in 300-cycle no-grant test.
